// File: rtl/mult_accumulator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mult_accumulator
// Description : Sums Max_Count unsigned products from an upstream multiplier
//               into a saturating accumulator. The final sum is offered with
//               a valid/ready handshake; a sticky flag reports saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_accumulator #(
   parameter int Width     = 8,
   parameter int Acc_Width = 10,
   parameter int Max_Count = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic [Width-1:0]     product,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [Acc_Width-1:0] acc_out,
   output logic [3:0]           count,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 overflow
);

   // Sum is one bit wider than the wider operand so a carry is never lost
   // before the saturation compare.
   localparam int c_SUM_W = ((Width > Acc_Width) ? Width : Acc_Width) + 1;
   localparam logic [c_SUM_W-1:0] c_ACC_MAX =
      {{(c_SUM_W-Acc_Width){1'b0}}, {Acc_Width{1'b1}}};
   localparam logic [3:0] c_MAX_CNT = 4'(Max_Count);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [Acc_Width-1:0] acc_q, acc_d;
   logic [3:0]           cnt_q, cnt_d;
   logic                 ovf_q, ovf_d;

   logic [c_SUM_W-1:0]   w_base;
   logic [c_SUM_W-1:0]   w_sum;
   logic                 w_sat;
   logic [Acc_Width-1:0] w_acc_next;

   // Handshake outputs decode only the registered state, so there is no
   // combinational path from in_valid or out_ready.
   assign in_ready  = (state_q != DONE);
   assign out_valid = (state_q == DONE);
   assign acc_out   = acc_q;
   assign count     = cnt_q;
   assign overflow  = ovf_q;

   // A batch starts from zero in IDLE; otherwise add onto the running sum.
   // Once saturated, acc_q is the maximum so any further sum also clamps.
   assign w_base     = (state_q == IDLE) ? '0 : c_SUM_W'(acc_q);
   assign w_sum      = w_base + c_SUM_W'(product);
   assign w_sat      = (w_sum > c_ACC_MAX);
   assign w_acc_next = w_sat ? {Acc_Width{1'b1}} : w_sum[Acc_Width-1:0];

   // State register with immediate (asynchronous) reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   // Next-state and datapath: clear beats accept and the DONE handshake.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      if (clear) begin
         state_d = IDLE;
         acc_d   = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  acc_d   = w_acc_next;
                  cnt_d   = 4'd1;
                  ovf_d   = w_sat;
                  state_d = ACCUM;
               end
            end
            ACCUM: begin
               if (in_valid) begin
                  acc_d = w_acc_next;
                  cnt_d = cnt_q + 4'd1;
                  ovf_d = ovf_q | w_sat;
                  if ((cnt_q + 4'd1) == c_MAX_CNT) begin
                     state_d = DONE;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_d = IDLE;
                  acc_d   = '0;
                  cnt_d   = '0;
                  ovf_d   = 1'b0;
               end
            end
            default: begin
               state_d = IDLE;
               acc_d   = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mult_accumulator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mult_accumulator
// Description : Self-checking bench for mult_accumulator. A batch-level model
//               (total of accepted products, clamped) predicts every output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_accumulator;

   localparam int c_MC      = 8;
   localparam int c_ACC_MAX = 1023;

   logic       clk = 1'b0;
   logic       rst;
   logic       clear, in_valid, in_ready, out_valid, out_ready, overflow;
   logic [7:0] product;
   logic [9:0] acc_out;
   logic [3:0] count;

   logic       clear4, in_valid4, in_ready4, out_valid4, out_ready4, overflow4;
   logic [7:0] product4;
   logic [9:0] acc_out4;
   logic [3:0] count4;

   int n_checks = 0;
   int n_fail   = 0;

   // Batch model: plain running total of accepted products.
   int m_total;
   int m_cnt;
   bit m_done;

   always #5 clk = ~clk;

   mult_accumulator u_dut (
      .clk(clk), .rst(rst), .clear(clear), .product(product),
      .in_valid(in_valid), .in_ready(in_ready), .acc_out(acc_out),
      .count(count), .out_valid(out_valid), .out_ready(out_ready),
      .overflow(overflow)
   );

   mult_accumulator #(.Width(8), .Acc_Width(10), .Max_Count(4)) u_dut4 (
      .clk(clk), .rst(rst), .clear(clear4), .product(product4),
      .in_valid(in_valid4), .in_ready(in_ready4), .acc_out(acc_out4),
      .count(count4), .out_valid(out_valid4), .out_ready(out_ready4),
      .overflow(overflow4)
   );

   function automatic logic [16:0] exp_vec();
      int a;
      a = (m_total > c_ACC_MAX) ? c_ACC_MAX : m_total;
      return {10'(a), 4'(m_cnt), (m_total > c_ACC_MAX), m_done, !m_done};
   endfunction

   function automatic logic [16:0] got_vec();
      return {acc_out, count, overflow, out_valid, in_ready};
   endfunction

   task automatic model_reset();
      m_total = 0;
      m_cnt   = 0;
      m_done  = 1'b0;
   endtask

   // Drive one clock cycle on the default-parameter DUT and advance the model.
   task automatic step(input logic v, input logic [7:0] p, input logic clr,
                       input logic ordy);
      in_valid  = v;
      product   = p;
      clear     = clr;
      out_ready = ordy;
      @(posedge clk);
      if (clr) begin
         model_reset();
      end else if (m_done) begin
         if (ordy) model_reset();
      end else if (v) begin
         m_total = m_total + int'(p);
         m_cnt   = m_cnt + 1;
         if (m_cnt == c_MC) m_done = 1'b1;
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 0; product = 0; clear = 0; out_ready = 0;
      in_valid4 = 0; product4 = 0; clear4 = 0; out_ready4 = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (got_vec() !== {10'd0, 4'd0, 1'b0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_state got=%h exp=%h", got_vec(), {10'd0, 4'd0, 1'b0, 1'b0, 1'b1});
      end
      rst = 1'b0;
      step(0, 8'd0, 0, 1);
      n_checks++;
      if (got_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL reset_idle_out_ready got=%h exp=%h", got_vec(), exp_vec());
      end
   endtask

   task automatic test_nominal();
      for (int i = 0; i < 8; i++) begin
         step(1, 8'd20, 0, 0);
         n_checks++;
         if (got_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL nominal_step%0d got=%h exp=%h", i, got_vec(), exp_vec());
         end
      end
      n_checks++;
      if (got_vec() !== {10'd160, 4'd8, 1'b0, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL nominal_final got=%h exp=%h", got_vec(), {10'd160, 4'd8, 1'b0, 1'b1, 1'b0});
      end
      step(0, 8'd0, 0, 1);
      n_checks++;
      if (got_vec() !== {10'd0, 4'd0, 1'b0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL nominal_drain got=%h exp=%h", got_vec(), {10'd0, 4'd0, 1'b0, 1'b0, 1'b1});
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 8; i++) begin
         step(1, 8'd225, 0, 0);
         n_checks++;
         if (got_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL sat_step%0d got=%h exp=%h", i, got_vec(), exp_vec());
         end
         if (i == 4) begin
            n_checks++;
            if (acc_out !== 10'd1023 || overflow !== 1'b1) begin
               n_fail++;
               $display("FAIL sat_clamp acc=%0d ovf=%b exp acc=1023 ovf=1", acc_out, overflow);
            end
         end
      end
      n_checks++;
      if (got_vec() !== {10'd1023, 4'd8, 1'b1, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL sat_final got=%h exp=%h", got_vec(), {10'd1023, 4'd8, 1'b1, 1'b1, 1'b0});
      end
      step(0, 8'd0, 0, 1);
   endtask

   task automatic test_backpressure();
      logic [16:0] held;
      for (int i = 0; i < 8; i++) step(1, 8'($urandom_range(0, 255)), 0, 0);
      held = exp_vec();
      for (int i = 0; i < 5; i++) begin
         step(1'(i % 2 == 0), 8'($urandom_range(1, 255)), 0, 0);
         n_checks++;
         if (got_vec() !== held || got_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL backpressure_hold%0d got=%h exp=%h", i, got_vec(), held);
         end
      end
      step(1, 8'd77, 0, 1);
      n_checks++;
      if (acc_out !== 10'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 4'd0) begin
         n_fail++;
         $display("FAIL backpressure_release got=%h exp=%h", got_vec(), {10'd0, 4'd0, 1'b0, 1'b0, 1'b1});
      end
   endtask

   task automatic test_gaps();
      logic [7:0] prods [4];
      logic       vseq  [8];
      int         sum, cnt, k;
      prods = '{8'd15, 8'd45, 8'd156, 8'd0};
      vseq  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      sum = 0; cnt = 0; k = 0;
      for (int i = 0; i < 8; i++) begin
         in_valid4  = vseq[i];
         product4   = vseq[i] ? prods[k] : 8'd99;
         out_ready4 = 1'b0;
         @(posedge clk);
         if (vseq[i]) begin
            sum = sum + int'(prods[k]);
            cnt = cnt + 1;
            k   = k + 1;
         end
         #1;
         n_checks++;
         if (acc_out4 !== 10'(sum) || count4 !== 4'(cnt) || out_valid4 !== (cnt == 4)) begin
            n_fail++;
            $display("FAIL gaps_cycle%0d acc=%0d cnt=%0d ov=%b exp acc=%0d cnt=%0d ov=%b",
                     i, acc_out4, count4, out_valid4, sum, cnt, (cnt == 4));
         end
      end
      n_checks++;
      if (acc_out4 !== 10'd216 || out_valid4 !== 1'b1) begin
         n_fail++;
         $display("FAIL gaps_final acc=%0d ov=%b exp acc=216 ov=1", acc_out4, out_valid4);
      end
      in_valid4 = 1'b0; out_ready4 = 1'b1;
      @(posedge clk); #1;
      out_ready4 = 1'b0;
      n_checks++;
      if (acc_out4 !== 10'd0 || out_valid4 !== 1'b0 || count4 !== 4'd0) begin
         n_fail++;
         $display("FAIL gaps_drain acc=%0d ov=%b cnt=%0d exp 0", acc_out4, out_valid4, count4);
      end
   endtask

   task automatic test_clear();
      for (int i = 0; i < 3; i++) step(1, 8'($urandom_range(1, 255)), 0, 0);
      step(1, 8'd50, 1, 0);
      n_checks++;
      if (got_vec() !== {10'd0, 4'd0, 1'b0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL clear_mid got=%h exp=%h", got_vec(), {10'd0, 4'd0, 1'b0, 1'b0, 1'b1});
      end
      for (int i = 0; i < 8; i++) step(1, 8'd200, 0, 0);
      step(0, 8'd0, 1, 1);
      n_checks++;
      if (got_vec() !== exp_vec() || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_done got=%h exp=%h", got_vec(), exp_vec());
      end
   endtask

   task automatic test_async_rst();
      for (int i = 0; i < 8; i++) step(1, 8'd180, 0, 0);
      #3;
      rst = 1'b1;
      #1;
      n_checks++;
      if (got_vec() !== {10'd0, 4'd0, 1'b0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL async_rst got=%h exp=%h", got_vec(), {10'd0, 4'd0, 1'b0, 1'b0, 1'b1});
      end
      #1;
      rst = 1'b0;
      model_reset();
      step(1, 8'd33, 0, 0);
      n_checks++;
      if (got_vec() !== exp_vec() || acc_out !== 10'd33 || count !== 4'd1) begin
         n_fail++;
         $display("FAIL rst_first_accept got=%h exp=%h", got_vec(), exp_vec());
      end
      step(0, 8'd0, 1, 0);
   endtask

   task automatic test_back_to_back();
      for (int b = 0; b < 2; b++) begin
         for (int i = 0; i < 8; i++) step(1, 8'($urandom_range(0, 255)), 0, 1);
         n_checks++;
         if (got_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL b2b_batch%0d got=%h exp=%h", b, got_vec(), exp_vec());
         end
         step(1, 8'd5, 0, 1);
         n_checks++;
         if (got_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL b2b_handoff%0d got=%h exp=%h", b, got_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
              1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 1)));
         n_checks++;
         if (got_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL random_cycle%0d got=%h exp=%h", i, got_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_nominal();
      test_saturation();
      test_backpressure();
      test_gaps();
      test_clear();
      test_async_rst();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
